led_fade_driver: RTL and testbench



---
 rtl/led_fade_pkg.sv | 26 ++
 rtl/led_fade_channel.sv | 81 ++++++++
 rtl/led_fade_driver.sv | 62 ++++++
 tb/tb_led_fade_driver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/led_fade_pkg.sv
// Shared types, defaults and level saturation helpers for the LED fader.
package led_fade_pkg;

  typedef enum logic [1:0] {
    IDLE_OFF,
    RISE,
    IDLE_ON,
    FALL
  } ch_state_t;

  localparam int N_LED_D     = 8;
  localparam int PWM_BITS_D  = 8;
  localparam int PRESCALE_D  = 195;
  localparam int FADE_STEP_D = 4;

  function automatic int lvl_rise(int lvl, int step, int maxv);
    int s;
    s = lvl + step;
    return (s > maxv) ? maxv : s;
  endfunction

  function automatic int lvl_fall(int lvl, int step);
    return (lvl < step) ? 0 : lvl - step;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: fade FSM, brightness level and PWM compare flop.
// LED_FADE_ACTIVE_LOW_EN inverts the drive for active-low boards.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS  = PWM_BITS_D,
  parameter int FADE_STEP = FADE_STEP_D
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                target,
  input  logic                fade_en,
  input  logic                period_end,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                active
);

  localparam int MAXV = 2**PWM_BITS - 1;
  localparam logic [PWM_BITS-1:0] MAX_L = '1;

`ifdef LED_FADE_ACTIVE_LOW_EN
  localparam logic POL = 1'b1;
`else
  localparam logic POL = 1'b0;
`endif

  ch_state_t           state;
  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] up_lvl;
  logic [PWM_BITS-1:0] dn_lvl;

  assign up_lvl =
    PWM_BITS'(lvl_rise(int'(level), FADE_STEP, MAXV));
  assign dn_lvl =
    PWM_BITS'(lvl_fall(int'(level), FADE_STEP));
  assign active = (state == RISE) || (state == FALL);

  // A target flip takes priority; the level only moves
  // on period_end while the target agrees with the direction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE_OFF;
      level <= '0;
    end else if (!fade_en) begin
      level <= target ? MAX_L : '0;
      state <= target ? IDLE_ON : IDLE_OFF;
    end else begin
      unique case (state)
        IDLE_OFF: if (target) state <= RISE;
        IDLE_ON:  if (!target) state <= FALL;
        RISE: begin
          if (!target) begin
            state <= FALL;
          end else if (period_end) begin
            level <= up_lvl;
            if (up_lvl == MAX_L) state <= IDLE_ON;
          end
        end
        FALL: begin
          if (target) begin
            state <= RISE;
          end else if (period_end) begin
            level <= dn_lvl;
            if (dn_lvl == '0) state <= IDLE_OFF;
          end
        end
        default: state <= IDLE_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led <= POL;
    end else begin
      led <= POL ^ ((level == MAX_L) || (level > pwm_cnt));
    end
  end

endmodule

// File: rtl/led_fade_driver.sv
// PWM fade driver for the PIO LED pattern: prescaler, PWM counter, busy.
// LED_FADE_ACTIVE_LOW_EN selects active-low led_out.
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int N_LED     = N_LED_D,
  parameter int PWM_BITS  = PWM_BITS_D,
  parameter int PRESCALE  = PRESCALE_D,
  parameter int FADE_STEP = FADE_STEP_D
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_LED-1:0] pattern_in,
  input  logic             fade_en,
  output logic [N_LED-1:0] led_out,
  output logic             busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]       pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_LED-1:0]    pattern_q;
  logic [N_LED-1:0]    active;
  logic                tick;
  logic                period_end;

  assign tick       = (pre_cnt == PRE_LAST);
  assign period_end = tick && (&pwm_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt   <= '0;
      pwm_cnt   <= '0;
      pattern_q <= '0;
      busy      <= 1'b0;
    end else begin
      pattern_q <= pattern_in;
      pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      busy      <= fade_en && (|active);
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .target     (pattern_q[i]),
      .fade_en    (fade_en),
      .period_end (period_end),
      .pwm_cnt    (pwm_cnt),
      .led        (led_out[i]),
      .active     (active[i])
    );
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver with a goal/moving brightness model.
// Honours LED_FADE_ACTIVE_LOW_EN when the build defines it.
module tb_led_fade_driver;

  localparam int P   = 2;
  localparam int B   = 4;
  localparam int S   = 4;
  localparam int M   = 15;
  localparam int PER = P * (M + 1);

`ifdef LED_FADE_ACTIVE_LOW_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif
  localparam logic [7:0] OFF_V = AL ? 8'hFF : 8'h00;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pattern_in;
  logic       fade_en;
  logic [7:0] led_out;
  logic       busy;

  always #5 clk = ~clk;

  led_fade_driver #(
    .N_LED     (8),
    .PWM_BITS  (B),
    .PRESCALE  (P),
    .FADE_STEP (S)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pattern_in (pattern_in),
    .fade_en    (fade_en),
    .led_out    (led_out),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] led;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Model: each LED has a brightness, a goal (on/off) and a moving flag
  int         lev  [8];
  bit         goal [8];
  bit         mov  [8];
  logic [7:0] pq;
  int         n;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      lev[i]  = 0;
      goal[i] = 1'b0;
      mov[i]  = 1'b0;
    end
    pq = 8'h00;
    n  = 0;
  endtask

  task automatic step();
    exp_t e;
    int   pwm;
    bit   pe;
    bit   anymov;
    @(posedge clk);
    #1;
    pwm    = (n / P) % (M + 1);
    pe     = (n % PER) == PER - 1;
    anymov = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e.led[i] = (lev[i] == M) || (lev[i] > pwm);
      anymov   = anymov | mov[i];
    end
    e.led  = e.led ^ {8{AL}};
    e.busy = fade_en && anymov;
    q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      if (!fade_en) begin
        lev[i]  = pq[i] ? M : 0;
        goal[i] = pq[i];
        mov[i]  = 1'b0;
      end else if (pq[i] != goal[i]) begin
        goal[i] = pq[i];
        mov[i]  = 1'b1;
      end else if (pe && mov[i]) begin
        if (goal[i]) lev[i] = (lev[i] + S > M) ? M : lev[i] + S;
        else         lev[i] = (lev[i] < S) ? 0 : lev[i] - S;
        if (lev[i] == (goal[i] ? M : 0)) mov[i] = 1'b0;
      end
    end
    pq = pattern_in;
    n++;
  endtask

  task automatic run(int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && q.size() > 0) begin
      e = q.pop_front();
      compared++;
      if (led_out !== e.led || busy !== e.busy) begin
        mismatched++;
        $display("FAIL scoreboard t=%0t led_out=%h busy=%b required %h %b",
                 $time, led_out, busy, e.led, e.busy);
      end
    end
  end

  initial begin
    bit seen;
    reset_n    = 1'b0;
    pattern_in = 8'hFF;
    fade_en    = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_led", led_out, OFF_V);
    check("reset_busy", {7'd0, busy}, 8'h00);

    @(negedge clk);
    reset_n = 1'b1;
    run(160);
    check("full_on_led", led_out, ~OFF_V);
    check("full_on_busy", {7'd0, busy}, 8'h00);

    pattern_in = 8'h00;
    run(160);
    pattern_in = 8'h01;
    run(64);
    pattern_in = 8'h00;
    run(110);
    check("reversal_off", led_out, OFF_V);
    check("reversal_busy", {7'd0, busy}, 8'h00);

    fade_en    = 1'b0;
    pattern_in = 8'hA5;
    run(3);
    check("bypass_led", led_out, 8'hA5 ^ {8{AL}});
    check("bypass_busy", {7'd0, busy}, 8'h00);
    fade_en    = 1'b1;
    pattern_in = 8'h5A;
    run(170);
    check("refade_led", led_out, 8'h5A ^ {8{AL}});

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) pattern_in = 8'($urandom);
      if ($urandom_range(0, 199) == 0) fade_en = ~fade_en;
      step();
    end

    fade_en    = 1'b0;
    pattern_in = 8'h00;
    run(3);
    fade_en    = 1'b1;
    pattern_in = 8'hFF;
    run(70);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      if (led_out != OFF_V) seen = 1'b1;
    end
    check("midfade_lit", {7'd0, seen}, 8'h01);
    #1;
    reset_n = 1'b0;
    q.delete();
    #1;
    check("async_reset_led", led_out, OFF_V);
    check("async_reset_busy", {7'd0, busy}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    reset_n    = 1'b1;
    pattern_in = 8'h0F;
    run(200);
    check("restart_led", led_out, 8'h0F ^ {8{AL}});
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
